mulu_x3y3_ctl: RTL
==================

# mulu_x3y3_ctl

Sequencing stage that feeds the combinational 3x3 unsigned multiplier and captures its product. Accepts packed operand pairs over a valid/ready handshake and holds them stable on the multiplier inputs until the multiplier's ready is seen. It then registers the product and presents it downstream under a second valid/ready handshake. An optional accumulator mode sums successive products.

## Interface
- `X_WIDTH`, default 3: multiplicand width.
- `Y_WIDTH`, default 3: multiplier width.
- `P_WIDTH`, default X_WIDTH+Y_WIDTH: product width.
- `ACC_WIDTH`, default P_WIDTH+2: output/accumulator width.
- `RDY_TIMEOUT`, default 15: maximum cycles spent waiting for `mul_rdy`.
- `clk`  in  1: clock; everything is rising-edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: block can accept an operand pair.
- `in_data`  in  X_WIDTH+Y_WIDTH: `[X_WIDTH-1:0]` = x, upper bits = y.
- `mul_x`  out  X_WIDTH: operand x to the multiplier.
- `mul_y`  out  Y_WIDTH: operand y to the multiplier.
- `mul_p`  in  P_WIDTH: product from the multiplier.
- `mul_rdy`  in  1: multiplier result valid; tie high for the combinational multiplier.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `out_data`  out  ACC_WIDTH: result.
- `err`  out  1: sticky timeout flag.
- `acc_clr`  in  1: accumulator clear. Present only with `MULU_ACC_EN`.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: every register 0. Outputs after reset are `in_ready`=1, `out_valid`=0, `out_data`=0, `mul_x`=0, `mul_y`=0, `err`=0.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` & `in_ready`: latch x and y into operand registers, clear the wait counter, go to CALC.
- CALC:
  - `mul_x`/`mul_y` are driven from the operand registers. They are stable throughout CALC and DONE.
  - Each cycle, sample `mul_rdy`:
    - If 1: capture `mul_p` zero-extended to ACC_WIDTH into the result register, then go to DONE.
    - Else if the wait counter equals RDY_TIMEOUT-1: result := 0, set `err`, go to DONE.
    - Else: increment the counter.
- DONE:
  - `out_valid`=1 and `out_data` holds the result.
  - On `out_ready`: go to IDLE.
  - `out_data` retains its value after leaving DONE until the next capture.
- `in_ready` is 1 only in IDLE; there is no operand acceptance in CALC or DONE.
- `err` clears only on reset.
- Reset asserted in any state aborts the in-flight operation; the result is discarded and no `out_valid` is produced.
- Arithmetic is unsigned. The product fits in P_WIDTH and is never truncated.

## Timing
- With `mul_rdy` tied high:
  - Accept at edge N.
  - CALC during cycle N+1; capture at edge N+2.
  - `out_valid`=1 from cycle N+2.
  - Latency is 2 cycles.
- Minimum initiation interval is 3 cycles (IDLE, CALC, DONE), reached when `out_ready` is held high.
- Timeout: `out_valid` rises RDY_TIMEOUT+1 cycles after accept.
- `out_valid` and `out_data` hold stable while `out_ready`=0; backpressure is unbounded.
- `in_valid` in a non-IDLE state is ignored. The upstream must hold `in_data` until `in_ready` is seen.

## Configuration
- `MULU_ACC_EN` defined:
  - An accumulator register of ACC_WIDTH bits is added.
  - At CALC capture: acc := acc + product, modulo 2^ACC_WIDTH (wraps silently), and `out_data` = new acc.
  - A timeout adds 0.
  - `acc_clr`=1 in any cycle sets acc := 0. If `acc_clr` coincides with a capture, the result is the product alone.
  - `out_data` does not change on `acc_clr` until the next capture.
- `MULU_ACC_EN` undefined:
  - There is no accumulator and no `acc_clr` port.
  - `out_data` = zero-extended product of the current operands.

## Test plan
- Basic multiply: reset, then x=7, y=7 with `mul_rdy`=1 and `out_ready`=1 → `out_valid` two cycles after accept with `out_data`=8'h31. `in_ready`=1 three cycles after accept.
- Exhaustive check: all 64 (x,y) pairs back-to-back → each `out_data` = x*y. No pair is lost or duplicated, and the initiation interval is 3.
- Backpressure: x=5, y=3 with `out_ready`=0 for 6 cycles → `out_data`=8'h0F stable and `in_ready`=0 throughout. The handshake completes on the cycle `out_ready` rises.
- Timeout: `mul_rdy`=0, x=2, y=3 → after RDY_TIMEOUT cycles in CALC, `out_data`=0 and `err`=1. `err` remains 1 through later successful operations until `rst_n`=0.
- Reset mid-operation: `rst_n`=0 during CALC → the next cycle is IDLE with `out_valid`=0 and all outputs 0. No stale result appears afterwards.
- Accumulate (`MULU_ACC_EN`):
  - 7*7 three times → `out_data` 49, 98, 147 (8'h93).
  - One more 7*7 → 196; then 7*7 → 245; then another → wraps to 38.
  - `acc_clr` pulsed, then 2*3 → `out_data`=6.

Source files
------------

// File: rtl/mulu_x3y3_ctl.sv
// Purpose : sequences operand pairs into the 3x3 unsigned multiplier and registers its product.
// Latency : 2 cycles from accept to out_valid with mul_rdy high; RDY_TIMEOUT+1 on timeout.
// Backpressure: one operation in flight; in_ready low outside IDLE, result held until out_ready.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - operand handshake, in_data = {y, x}
//   mul_x, mul_y, mul_p   - operands to / product from the external multiplier
//   mul_rdy               - multiplier result valid (tie high for a combinational multiplier)
//   out_valid/out_ready   - result handshake, out_data = product (or running sum)
//   err                   - sticky flag, set when mul_rdy never arrived within RDY_TIMEOUT cycles
//   acc_clr               - accumulator clear, only when MULU_ACC_EN is defined
//
// Build option: define MULU_ACC_EN to add the product accumulator and the acc_clr port.

module mulu_x3y3_ctl #(
  parameter int X_WIDTH     = 3,
  parameter int Y_WIDTH     = 3,
  parameter int P_WIDTH     = X_WIDTH + Y_WIDTH,
  parameter int ACC_WIDTH   = P_WIDTH + 2,
  parameter int RDY_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [X_WIDTH+Y_WIDTH-1:0] in_data,
  output logic [X_WIDTH-1:0]         mul_x,
  output logic [Y_WIDTH-1:0]         mul_y,
  input  logic [P_WIDTH-1:0]         mul_p,
  input  logic                       mul_rdy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_data,
  output logic                       err
`ifdef MULU_ACC_EN
  ,
  input  logic                       acc_clr
`endif
);

  // Counter only has to reach RDY_TIMEOUT-1.
  localparam int CNT_W = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [X_WIDTH-1:0]   x_q;
  logic [Y_WIDTH-1:0]   y_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ACC_WIDTH-1:0] res_q;
  logic                 err_q;

  logic                 accept;
  logic                 capture;
  logic                 timeout;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] cap_val;
  logic [ACC_WIDTH-1:0] to_val;

  assign accept   = in_valid && in_ready;
  assign capture  = (state_q == CALC) && mul_rdy;
  // mul_rdy wins over the timeout if both land in the same cycle.
  assign timeout  = (state_q == CALC) && !mul_rdy &&
                    (cnt_q == CNT_W'(RDY_TIMEOUT - 1));
  assign prod_ext = ACC_WIDTH'(mul_p);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (capture || timeout) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- result selection
`ifdef MULU_ACC_EN
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_base;

  // A clear coinciding with a capture restarts the sum from this product.
  assign acc_base = acc_clr ? '0 : acc_q;
  assign cap_val  = acc_base + prod_ext;   // wraps modulo 2^ACC_WIDTH
  assign to_val   = acc_base;              // a timeout contributes nothing

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (capture) begin
      acc_q <= cap_val;
    end else if (acc_clr) begin
      acc_q <= '0;
    end
  end
`else
  assign cap_val = prod_ext;
  assign to_val  = '0;
`endif

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        x_q   <= in_data[X_WIDTH-1:0];
        y_q   <= in_data[X_WIDTH+Y_WIDTH-1:X_WIDTH];
        cnt_q <= '0;
      end else if ((state_q == CALC) && !mul_rdy && !timeout) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // out_data only moves on a capture or timeout; it survives the return to IDLE.
      if (capture) begin
        res_q <= cap_val;
      end else if (timeout) begin
        res_q <= to_val;
      end

      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mul_x    = x_q;
  assign mul_y    = y_q;
  assign out_data = res_q;
  assign err      = err_q;

endmodule
